// File: rtl/mips_program_loader_if.sv
// Instruction-field stream feeding the MIPS program loader.
// The producer drives the decoded fields plus valid/last and the loader answers with ready.
interface mips_program_loader_if;
    logic        valid;
    logic        ready;
    logic [2:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        last;

    modport master (
        output valid, op, rs, rt, rd, funct, imm, last,
        input  ready
    );

    modport slave (
        input  valid, op, rs, rt, rd, funct, imm, last,
        output ready
    );
endinterface

// File: rtl/mips_program_loader.sv
// MIPS program loader: packs decoded instruction fields into 32-bit MIPS words
// and writes them to consecutive instruction-memory addresses, keeping the core
// held off until the whole program is in memory.
module mips_program_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    mips_program_loader_if.slave s_in,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W:0]   o_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic [31:0]       r_wdata;
    logic              r_last;

    logic              w_accept;
    logic              w_legal;
    logic              w_clear;
    logic [31:0]       w_encoded;

    // Fields are taken only while loading; ops 5..7 have no encoding.
    assign w_accept = (r_state == S_LOAD) && s_in.valid;
    assign w_legal  = (s_in.op <= 3'd4);
    assign w_clear  = i_start &&
                      ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

    // Pack the incoming fields into the opcode layout the core's decoder expects (shamt always 0).
    always_comb begin
        w_encoded = 32'h0000_0000;
        case (s_in.op)
            3'd0:    w_encoded = {6'b000000, s_in.rs, s_in.rt, s_in.rd, 5'b00000, s_in.funct};
            3'd1:    w_encoded = {6'b100011, s_in.rs, s_in.rt, s_in.imm};
            3'd2:    w_encoded = {6'b101011, s_in.rs, s_in.rt, s_in.imm};
            3'd3:    w_encoded = {6'b000100, s_in.rs, s_in.rt, s_in.imm};
            3'd4:    w_encoded = {6'b001000, s_in.rs, s_in.rt, s_in.imm};
            default: w_encoded = 32'h0000_0000;
        endcase
    end

    // Next-state logic: a write always follows an accepted legal word, and the
    // last slot of memory without a last flag is treated as overflow.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_nextState = S_LOAD;
            S_LOAD: begin
                if (w_accept) begin
                    w_nextState = w_legal ? S_WRITE : S_ERR;
                end
            end
            S_WRITE: begin
                if (r_last) begin
                    w_nextState = S_DONE;
                end else if (r_addr == LAST_ADDR) begin
                    w_nextState = S_ERR;
                end else begin
                    w_nextState = S_LOAD;
                end
            end
            S_DONE:  if (i_start) w_nextState = S_LOAD;
            S_ERR:   if (i_start) w_nextState = S_LOAD;
            default: w_nextState = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Address/count bookkeeping and capture of the encoded word for the following write cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_count <= '0;
            r_wdata <= 32'h0000_0000;
            r_last  <= 1'b0;
        end else begin
            if (w_clear) begin
                r_addr  <= '0;
                r_count <= '0;
            end else if (r_state == S_WRITE) begin
                r_addr  <= r_addr + ADDR_ONE;
                r_count <= r_count + CNT_ONE;
            end
            if (w_accept && w_legal) begin
                r_wdata <= w_encoded;
                r_last  <= s_in.last;
            end
        end
    end

    assign s_in.ready   = (r_state == S_LOAD);
    assign o_imem_we    = (r_state == S_WRITE);
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = r_wdata;
    assign o_cpu_hold   = (r_state != S_DONE);
    assign o_done       = (r_state == S_DONE);
    assign o_err        = (r_state == S_ERR);
    assign o_count      = r_count;

endmodule

// File: tb/tb_mips_program_loader.sv
// Directed testbench for mips_program_loader. Two instances share one stimulus
// stream: dutA uses the default 8-bit address, dutB a 2-bit address so memory
// overflow is reachable in a few words.
module tb_mips_program_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        valid;
    logic [2:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        last;

    logic        readyA, weA, holdA, doneA, errA;
    logic [7:0]  addrA;
    logic [31:0] wdataA;
    logic [8:0]  countA;

    logic        readyB, weB, holdB, doneB, errB;
    logic [1:0]  addrB;
    logic [31:0] wdataB;
    logic [2:0]  countB;

    logic [7:0]  logAddrA[$];
    logic [31:0] logDataA[$];
    logic [1:0]  logAddrB[$];
    logic [31:0] logDataB[$];

    int checkCount = 0;
    int passCount  = 0;

    mips_program_loader_if busA ();
    mips_program_loader_if busB ();

    assign busA.valid = valid;
    assign busA.op    = op;
    assign busA.rs    = rs;
    assign busA.rt    = rt;
    assign busA.rd    = rd;
    assign busA.funct = funct;
    assign busA.imm   = imm;
    assign busA.last  = last;
    assign readyA     = busA.ready;

    assign busB.valid = valid;
    assign busB.op    = op;
    assign busB.rs    = rs;
    assign busB.rt    = rt;
    assign busB.rd    = rd;
    assign busB.funct = funct;
    assign busB.imm   = imm;
    assign busB.last  = last;
    assign readyB     = busB.ready;

    mips_program_loader #(.ADDR_W(8)) dutA (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start),
        .s_in         (busA),
        .o_imem_we    (weA),
        .o_imem_addr  (addrA),
        .o_imem_wdata (wdataA),
        .o_cpu_hold   (holdA),
        .o_done       (doneA),
        .o_err        (errA),
        .o_count      (countA)
    );

    mips_program_loader #(.ADDR_W(2)) dutB (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start),
        .s_in         (busB),
        .o_imem_we    (weB),
        .o_imem_addr  (addrB),
        .o_imem_wdata (wdataB),
        .o_cpu_hold   (holdB),
        .o_done       (doneB),
        .o_err        (errB),
        .o_count      (countB)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write seen by each instance.
    always @(negedge clk) begin
        if (weA === 1'b1) begin
            logAddrA.push_back(addrA);
            logDataA.push_back(wdataA);
        end
        if (weB === 1'b1) begin
            logAddrB.push_back(addrB);
            logDataB.push_back(wdataB);
        end
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        logAddrA.delete(); logDataA.delete();
        logAddrB.delete(); logDataB.delete();
    endtask

    // Called at a negedge; returns at the negedge after start was sampled.
    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge just after the word was accepted.
    task automatic sendWord(input logic [2:0] opIn, input logic [4:0] rsIn, input logic [4:0] rtIn,
                            input logic [4:0] rdIn, input logic [5:0] functIn, input logic [15:0] immIn,
                            input logic lastIn);
        int budget;
        budget = 0;
        op = opIn; rs = rsIn; rt = rtIn; rd = rdIn; funct = functIn; imm = immIn; last = lastIn;
        valid = 1'b1;
        while (readyA !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20) begin
            checkCount++;
            $display("[TB] FAIL send_timeout: in_ready never rose, got %b want 1", readyA);
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        checkCount++; if (readyA !== 1'b0)        $display("[TB] FAIL rst_ready: got %b want 0", readyA); else passCount++;
        checkCount++; if (weA !== 1'b0)           $display("[TB] FAIL rst_we: got %b want 0", weA); else passCount++;
        checkCount++; if (addrA !== 8'h00)        $display("[TB] FAIL rst_addr: got %h want 00", addrA); else passCount++;
        checkCount++; if (wdataA !== 32'h0)       $display("[TB] FAIL rst_wdata: got %h want 0", wdataA); else passCount++;
        checkCount++; if (holdA !== 1'b1)         $display("[TB] FAIL rst_hold: got %b want 1", holdA); else passCount++;
        checkCount++; if (doneA !== 1'b0)         $display("[TB] FAIL rst_done: got %b want 0", doneA); else passCount++;
        checkCount++; if (errA !== 1'b0)          $display("[TB] FAIL rst_err: got %b want 0", errA); else passCount++;
        checkCount++; if (countA !== 9'd0)        $display("[TB] FAIL rst_count: got %0d want 0", countA); else passCount++;
        // Asynchronous reset while the second word is being written.
        pulseStart();
        sendWord(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000, 1'b0);
        @(negedge clk);
        sendWord(3'd1, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0004, 1'b0);
        checkCount++; if (weA !== 1'b1)           $display("[TB] FAIL midwrite_we: got %b want 1", weA); else passCount++;
        checkCount++; if (countA !== 9'd1)        $display("[TB] FAIL midwrite_count: got %0d want 1", countA); else passCount++;
        #2;
        rst = 1'b1;
        #1;
        checkCount++; if (weA !== 1'b0)           $display("[TB] FAIL async_we: got %b want 0", weA); else passCount++;
        checkCount++; if (holdA !== 1'b1)         $display("[TB] FAIL async_hold: got %b want 1", holdA); else passCount++;
        checkCount++; if (doneA !== 1'b0)         $display("[TB] FAIL async_done: got %b want 0", doneA); else passCount++;
        checkCount++; if (countA !== 9'd0)        $display("[TB] FAIL async_count: got %0d want 0", countA); else passCount++;
        checkCount++; if (addrA !== 8'h00)        $display("[TB] FAIL async_addr: got %h want 00", addrA); else passCount++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_load();
        $display("[TB] test_basic_load");
        doReset();
        pulseStart();
        sendWord(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000, 1'b0);
        sendWord(3'd1, 5'd1, 5'd2, 5'd0, 6'h00, 16'h0004, 1'b1);
        @(negedge clk);
        checkCount++; if (logDataA.size() !== 2)  $display("[TB] FAIL basic_nwrites: got %0d want 2", logDataA.size()); else passCount++;
        if (logDataA.size() == 2) begin
            checkCount++; if (logAddrA[0] !== 8'd0 || logDataA[0] !== 32'h00221820) $display("[TB] FAIL basic_w0: got %h@%0d want 00221820@0", logDataA[0], logAddrA[0]); else passCount++;
            checkCount++; if (logAddrA[1] !== 8'd1 || logDataA[1] !== 32'h8C220004) $display("[TB] FAIL basic_w1: got %h@%0d want 8c220004@1", logDataA[1], logAddrA[1]); else passCount++;
        end
        checkCount++; if (doneA !== 1'b1)         $display("[TB] FAIL basic_done: got %b want 1", doneA); else passCount++;
        checkCount++; if (errA !== 1'b0)          $display("[TB] FAIL basic_err: got %b want 0", errA); else passCount++;
        checkCount++; if (countA !== 9'd2)        $display("[TB] FAIL basic_count: got %0d want 2", countA); else passCount++;
        checkCount++; if (holdA !== 1'b0)         $display("[TB] FAIL basic_hold: got %b want 0", holdA); else passCount++;
        checkCount++; if (addrA !== 8'd2)         $display("[TB] FAIL basic_addr: got %0d want 2", addrA); else passCount++;
    endtask

    task automatic test_itypes();
        $display("[TB] test_itypes");
        doReset();
        pulseStart();
        // rd/funct carry junk on I-types; they must not leak into the word.
        sendWord(3'd2, 5'd1, 5'd2, 5'd31, 6'h3F, 16'h0008, 1'b0);
        sendWord(3'd3, 5'd1, 5'd2, 5'd31, 6'h3F, 16'hFFFF, 1'b0);
        sendWord(3'd4, 5'd0, 5'd5, 5'd31, 6'h3F, 16'h0007, 1'b1);
        @(negedge clk);
        checkCount++; if (logDataA.size() !== 3)  $display("[TB] FAIL itype_nwrites: got %0d want 3", logDataA.size()); else passCount++;
        if (logDataA.size() == 3) begin
            checkCount++; if (logAddrA[0] !== 8'd0 || logDataA[0] !== 32'hAC220008) $display("[TB] FAIL itype_sw: got %h@%0d want ac220008@0", logDataA[0], logAddrA[0]); else passCount++;
            checkCount++; if (logAddrA[1] !== 8'd1 || logDataA[1] !== 32'h1022FFFF) $display("[TB] FAIL itype_beq: got %h@%0d want 1022ffff@1", logDataA[1], logAddrA[1]); else passCount++;
            checkCount++; if (logAddrA[2] !== 8'd2 || logDataA[2] !== 32'h20050007) $display("[TB] FAIL itype_addi: got %h@%0d want 20050007@2", logDataA[2], logAddrA[2]); else passCount++;
        end
        checkCount++; if (doneA !== 1'b1 || countA !== 9'd3) $display("[TB] FAIL itype_done: got done=%b count=%0d want done=1 count=3", doneA, countA); else passCount++;
    endtask

    task automatic test_start_with_valid();
        $display("[TB] test_start_with_valid");
        doReset();
        start = 1'b1; valid = 1'b1;
        op = 3'd1; rs = 5'd3; rt = 5'd4; rd = 5'd0; funct = 6'h00; imm = 16'h0010; last = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkCount++; if (readyA !== 1'b1)        $display("[TB] FAIL sv_ready: got %b want 1", readyA); else passCount++;
        checkCount++; if (weA !== 1'b0)           $display("[TB] FAIL sv_nowrite: got %b want 0", weA); else passCount++;
        @(negedge clk);
        valid = 1'b0;
        checkCount++; if (weA !== 1'b1 || addrA !== 8'd0 || wdataA !== 32'h8C640010) $display("[TB] FAIL sv_write: got we=%b %h@%0d want we=1 8c640010@0", weA, wdataA, addrA); else passCount++;
        @(negedge clk);
        checkCount++; if (doneA !== 1'b1 || countA !== 9'd1) $display("[TB] FAIL sv_done: got done=%b count=%0d want done=1 count=1", doneA, countA); else passCount++;
    endtask

    task automatic test_illegal_op();
        $display("[TB] test_illegal_op");
        doReset();
        pulseStart();
        sendWord(3'd0, 5'd4, 5'd5, 5'd6, 6'h22, 16'h0000, 1'b0);
        @(negedge clk);
        sendWord(3'd6, 5'd1, 5'd1, 5'd1, 6'h01, 16'h1234, 1'b0);
        checkCount++; if (errA !== 1'b1)          $display("[TB] FAIL ill_err: got %b want 1", errA); else passCount++;
        checkCount++; if (doneA !== 1'b0)         $display("[TB] FAIL ill_done: got %b want 0", doneA); else passCount++;
        checkCount++; if (countA !== 9'd1)        $display("[TB] FAIL ill_count: got %0d want 1", countA); else passCount++;
        checkCount++; if (holdA !== 1'b1)         $display("[TB] FAIL ill_hold: got %b want 1", holdA); else passCount++;
        @(negedge clk);
        @(negedge clk);
        checkCount++; if (logDataA.size() !== 1)  $display("[TB] FAIL ill_nwrites: got %0d want 1", logDataA.size()); else passCount++;
        if (logDataA.size() == 1) begin
            checkCount++; if (logAddrA[0] !== 8'd0 || logDataA[0] !== 32'h00853022) $display("[TB] FAIL ill_w0: got %h@%0d want 00853022@0", logDataA[0], logAddrA[0]); else passCount++;
        end
        pulseStart();
        checkCount++; if (errA !== 1'b0 || countA !== 9'd0 || addrA !== 8'd0) $display("[TB] FAIL ill_restart: got err=%b count=%0d addr=%0d want 0/0/0", errA, countA, addrA); else passCount++;
        checkCount++; if (readyA !== 1'b1)        $display("[TB] FAIL ill_restart_ready: got %b want 1", readyA); else passCount++;
    endtask

    task automatic test_overflow();
        logic [31:0] expWord;
        $display("[TB] test_overflow");
        doReset();
        pulseStart();
        for (int k = 0; k < 4; k++) begin
            sendWord(3'd4, 5'(k), 5'(k + 1), 5'd0, 6'h00, 16'h0040 + 16'(k), 1'b0);
            if (k < 3) @(negedge clk);
        end
        @(negedge clk);
        checkCount++; if (errB !== 1'b1 || doneB !== 1'b0) $display("[TB] FAIL ovf_err: got err=%b done=%b want err=1 done=0", errB, doneB); else passCount++;
        checkCount++; if (countB !== 3'd4)        $display("[TB] FAIL ovf_count: got %0d want 4", countB); else passCount++;
        checkCount++; if (logDataB.size() !== 4)  $display("[TB] FAIL ovf_nwrites: got %0d want 4", logDataB.size()); else passCount++;
        expWord = 32'h20640043;
        if (logDataB.size() == 4) begin
            checkCount++; if (logAddrB[3] !== 2'd3 || logDataB[3] !== expWord) $display("[TB] FAIL ovf_w3: got %h@%0d want %h@3", logDataB[3], logAddrB[3], expWord); else passCount++;
        end
        checkCount++; if (errA !== 1'b0 || countA !== 9'd4) $display("[TB] FAIL ovf_wide: got err=%b count=%0d want err=0 count=4", errA, countA); else passCount++;
        // Same four words with last on the final slot: completes instead of overflowing.
        doReset();
        pulseStart();
        for (int k = 0; k < 4; k++) begin
            sendWord(3'd4, 5'(k), 5'(k + 1), 5'd0, 6'h00, 16'h0040 + 16'(k), k == 3);
            if (k < 3) @(negedge clk);
        end
        @(negedge clk);
        checkCount++; if (doneB !== 1'b1 || errB !== 1'b0) $display("[TB] FAIL full_done: got done=%b err=%b want done=1 err=0", doneB, errB); else passCount++;
        checkCount++; if (countB !== 3'd4)        $display("[TB] FAIL full_count: got %0d want 4", countB); else passCount++;
        checkCount++; if (holdB !== 1'b0 || addrB !== 2'd0) $display("[TB] FAIL full_hold_addr: got hold=%b addr=%0d want hold=0 addr=0", holdB, addrB); else passCount++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] expWord;
        $display("[TB] test_back_to_back");
        doReset();
        pulseStart();
        op = 3'd4; rs = 5'd0; rt = 5'd1; rd = 5'd0; funct = 6'h00; imm = 16'h0100; last = 1'b0;
        valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checkCount++; if (readyA !== 1'b1)    $display("[TB] FAIL b2b_ready_hi%0d: got %b want 1", k, readyA); else passCount++;
            @(negedge clk);
            expWord = {6'b001000, 5'(k), 5'(k + 1), 16'h0100 + 16'(k)};
            checkCount++; if (readyA !== 1'b0 || weA !== 1'b1) $display("[TB] FAIL b2b_wcycle%0d: got ready=%b we=%b want 0/1", k, readyA, weA); else passCount++;
            checkCount++; if (addrA !== 8'(k) || wdataA !== expWord) $display("[TB] FAIL b2b_word%0d: got %h@%0d want %h@%0d", k, wdataA, addrA, expWord, k); else passCount++;
            if (k < 5) begin
                rs = 5'(k + 1); rt = 5'(k + 2); imm = 16'h0100 + 16'(k + 1); last = (k == 4);
            end else begin
                valid = 1'b0;
            end
            @(negedge clk);
        end
        checkCount++; if (doneA !== 1'b1 || countA !== 9'd6) $display("[TB] FAIL b2b_done: got done=%b count=%0d want done=1 count=6", doneA, countA); else passCount++;
        checkCount++; if (logDataA.size() !== 6)  $display("[TB] FAIL b2b_nwrites: got %0d want 6", logDataA.size()); else passCount++;
    endtask

    // Test sequence.
    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0;
        op = 3'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; funct = 6'h00; imm = 16'h0000; last = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_load();
        test_itypes();
        test_start_with_valid();
        test_illegal_op();
        test_overflow();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
